// File: rtl/k_weight_fetch.sv
// k_weight_fetch: sequential reader for the banked weight memory.
// Walks a chosen bank from address 0 for a commanded number of 32-bit words,
// wrapping address then bank in fill order, and streams the returned words
// to the MAC array through a 2-entry credit-managed output FIFO.
//
// The FIFO is flow-through: the word returning from memory counts as an
// occupied entry in the cycle it appears on rd_data. This lets a beat go out
// in the same cycle the data returns. If that beat is not accepted, the word
// is written into storage so out_data stays stable while stalled.

module k_weight_fetch #(
    parameter int MEMW_SIZE = 3200,
    parameter int NUM_BANKS = 24,
    parameter int ADDR_W    = 12,
    parameter int BANK_W    = 5,
    parameter int CNT_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BANK_W-1:0] base_bank,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [BANK_W-1:0] rd_bank,
    input  logic [31:0]       rd_data,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEMW_SIZE - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   issue_left;    // reads still to be issued
    logic [CNT_W-1:0]   accept_left;   // beats still to be accepted downstream
    logic               in_flight;     // a read was issued last cycle; its data is on rd_data now

    logic [1:0]         fifo_count;    // words held in storage (0..2)
    logic               fifo_wr_ptr;
    logic               fifo_rd_ptr;
    logic [31:0]        fifo_mem [2];

    logic [1:0]         occupancy;
    logic               pop;
    logic               store;
    logic               credit_ok;
    logic               last_issue;
    logic               last_pop;

    // Stream view, credit check and read issue, all derived from current state.
    // NOTE: every signal assigned here gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        occupancy = fifo_count + {1'b0, in_flight};
        out_valid = (fifo_count != 2'd0) || in_flight;
        out_data  = '0;
        if (fifo_count != 2'd0) begin
            out_data = fifo_mem[fifo_rd_ptr];
        end else if (in_flight) begin
            out_data = rd_data;
        end
        pop        = out_valid && out_ready;
        // A returning word bypasses storage only if it is popped while storage is empty.
        store      = in_flight && !((fifo_count == 2'd0) && pop);
        // Issue only if, after this cycle's pop, at most one slot is taken;
        // that slot plus the new read then exactly fill the two entries.
        credit_ok  = (occupancy != 2'd2) || pop;
        rd_en      = (state == S_RUN) && (issue_left != '0) && credit_ok;
        last_issue = rd_en && (issue_left == CNT_W'(1));
        out_last   = out_valid && (accept_left == CNT_W'(1));
        last_pop   = pop && out_last;
    end

    // Command FSM: latches the command, walks the read pointer and counts beats.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_addr     <= '0;
            rd_bank     <= '0;
            issue_left  <= '0;
            accept_left <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (num_words != '0) begin
                            rd_addr     <= '0;
                            rd_bank     <= base_bank;
                            issue_left  <= num_words;
                            accept_left <= num_words;
                            busy        <= 1'b1;
                            state       <= S_RUN;
                        end else begin
                            // An empty command completes without touching memory or the stream.
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_RUN: begin
                    if (pop) begin
                        accept_left <= accept_left - CNT_W'(1);
                    end
                    if (rd_en) begin
                        issue_left <= issue_left - CNT_W'(1);
                        if (last_issue) begin
                            // The pointer stays on the final address once issue stops.
                            state <= S_DRAIN;
                        end else if (rd_addr == ADDR_LAST) begin
                            rd_addr <= '0;
                            rd_bank <= (rd_bank == BANK_LAST) ? '0 : rd_bank + BANK_W'(1);
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (pop) begin
                        accept_left <= accept_left - CNT_W'(1);
                    end
                    if (last_pop) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // In-flight tracking and FIFO pointers/occupancy; reset discards any returning read.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight   <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
        end else begin
            in_flight  <= rd_en;
            fifo_count <= fifo_count + {1'b0, store} - {1'b0, pop && (fifo_count != 2'd0)};
            if (store) begin
                fifo_wr_ptr <= ~fifo_wr_ptr;
            end
            if (pop && (fifo_count != 2'd0)) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
        end
    end

    // FIFO storage: captures the returning word whenever it is not consumed directly.
    // NOTE: storage has no reset; fifo_count gates every read of it, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (store) begin
            fifo_mem[fifo_wr_ptr] <= rd_data;
        end
    end

endmodule

// File: tb/tb_k_weight_fetch.sv
// Directed testbench for k_weight_fetch. A behavioural one-cycle-latency
// memory returns a word encoding {bank, addr}. Expected values come from the
// bench's own address/bank walk, never from the DUT.

module tb_k_weight_fetch;

    localparam int MEMW = 3200;
    localparam int NB   = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  base_bank;
    logic [16:0] num_words;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [4:0]  rd_bank;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int vectors     = 0;
    int miscompares = 0;

    k_weight_fetch #(
        .MEMW_SIZE (MEMW),
        .NUM_BANKS (NB),
        .ADDR_W    (12),
        .BANK_W    (5),
        .CNT_W     (17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_bank (base_bank),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_bank   (rd_bank),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input int bank, input int addr);
        return 32'hC000_0000 | (32'(bank) << 16) | 32'(addr);
    endfunction

    // Weight memory: one-cycle read latency; garbage when no read was issued.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem_word(int'(rd_bank), int'(rd_addr));
        else       rd_data <= 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_rd_en"}, rd_en, 1'b0);
        check({tag, "_rd_addr"}, {20'b0, rd_addr}, 32'd0);
        check({tag, "_rd_bank"}, {27'b0, rd_bank}, 32'd0);
        check1({tag, "_out_valid"}, out_valid, 1'b0);
        check1({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_out_data"}, out_data, 32'd0);
    endtask

    // Full-throughput command with out_ready held high. Cycle c counts from
    // the cycle after start: read i in cycle i+1, beat i in cycle i+2, done in n+2.
    // If poke>0, a conflicting start is pulsed in cycle poke and must be ignored.
    task automatic full_run(input int b0, input int n, input int poke);
        @(negedge clk);
        start     = 1'b1;
        base_bank = 5'(b0);
        num_words = 17'(n);
        out_ready = 1'b1;
        for (int c = 1; c <= n + 2; c++) begin
            logic exp_rd;
            logic exp_v;
            @(negedge clk);
            start     = (c == poke);
            base_bank = 5'd7;
            num_words = 17'd2;
            #1;
            exp_rd = (c <= n);
            exp_v  = (c >= 2) && (c <= n + 1);
            check1("run_rd_en", rd_en, exp_rd);
            if (exp_rd) begin
                check("run_rd_addr", {20'b0, rd_addr}, 32'((c - 1) % MEMW));
                check("run_rd_bank", {27'b0, rd_bank}, 32'((b0 + (c - 1) / MEMW) % NB));
            end
            check1("run_out_valid", out_valid, exp_v);
            if (exp_v) begin
                check("run_out_data", out_data,
                      mem_word((b0 + (c - 2) / MEMW) % NB, (c - 2) % MEMW));
            end
            check1("run_out_last", out_last, c == n + 1);
            check1("run_done", done, c == n + 2);
            check1("run_busy", busy, 1'b1);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check1("run_idle_busy", busy, 1'b0);
        check1("run_idle_done", done, 1'b0);
        check1("run_idle_rd_en", rd_en, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_bank = '0;
        num_words = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic fetch: bank 0, 4 words, reads addr 0..3, done six cycles after start
        full_run(0, 4, 0);

        // Zero-length command: done next cycle, no read, no beat, busy stays low
        @(negedge clk);
        start     = 1'b1;
        base_bank = 5'd3;
        num_words = 17'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check1("zero_done", done, 1'b1);
        check1("zero_busy", busy, 1'b0);
        check1("zero_rd_en", rd_en, 1'b0);
        check1("zero_out_valid", out_valid, 1'b0);
        @(negedge clk);
        #1;
        check1("zero_done_clear", done, 1'b0);
        check1("zero_busy_after", busy, 1'b0);
        check1("zero_out_valid_after", out_valid, 1'b0);

        // A start pulse during RUN is ignored; the original command completes unchanged
        full_run(1, 4, 2);

        // Bank crossing: bank 2 addr 3199 is followed by bank 3 addr 0, no bubble
        full_run(2, MEMW + 2, 0);

        // Bank wrap: from bank 23 the final read lands on bank 0 addr 0
        full_run(23, MEMW + 1, 0);

        // Backpressure: 8 words from bank 5 with out_ready pattern 1,0,0 repeating
        begin
            int   issued;
            int   accepted;
            logic done_seen;
            logic stall_prev;
            logic [31:0] held;
            issued     = 0;
            accepted   = 0;
            done_seen  = 1'b0;
            stall_prev = 1'b0;
            held       = '0;
            @(negedge clk);
            start     = 1'b1;
            base_bank = 5'd5;
            num_words = 17'd8;
            for (int c = 0; c < 100 && !done_seen; c++) begin
                logic pop_now;
                @(negedge clk);
                start     = 1'b0;
                out_ready = (c % 3 == 0);
                #1;
                pop_now = out_valid && out_ready;
                if (rd_en) begin
                    check("bp_rd_addr", {20'b0, rd_addr}, 32'(issued));
                    check("bp_rd_bank", {27'b0, rd_bank}, 32'd5);
                end
                check1("bp_credit", (issued - accepted + int'(rd_en) - int'(pop_now)) <= 2, 1'b1);
                if (stall_prev) begin
                    check1("bp_stall_valid", out_valid, 1'b1);
                    check("bp_stall_data", out_data, held);
                end
                if (out_valid) begin
                    check("bp_out_data", out_data, mem_word(5, accepted));
                    check1("bp_out_last", out_last, accepted == 7);
                end
                if (done) begin
                    done_seen = 1'b1;
                    check("bp_done_count", 32'(accepted), 32'd8);
                end
                if (rd_en)   issued++;
                if (pop_now) accepted++;
                stall_prev = out_valid && !out_ready;
                held       = out_data;
            end
            check1("bp_done_seen", done_seen, 1'b1);
            check("bp_issued", 32'(issued), 32'd8);
            check("bp_accepted", 32'(accepted), 32'd8);
            out_ready = 1'b1;
        end

        // Reset mid-RUN with a read in flight, then a clean fetch from addr 0
        @(negedge clk);
        start     = 1'b1;
        base_bank = 5'd4;
        num_words = 17'd6;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check1("rstrun_rd_en_c1", rd_en, 1'b1);
        @(negedge clk);
        #1;
        check1("rstrun_valid_c2", out_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check1("rstrun_rd_en_c3", rd_en, 1'b1);
        @(negedge clk);
        #1;
        check_reset_outputs("rstrun");
        rst = 1'b0;
        full_run(0, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
